// File: rtl/instruction_fetch_unit_pkg.sv
// Shared instruction-side definitions: fetch-unit state encodings, IFU-wide
// constants and next-PC operation codes, plus small address helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package instruction_fetch_unit_pkg;

    // Architectural reset vector and default memory wait budget
    localparam logic [31:0] IFU_RESET_PC    = 32'h0000_3000;
    localparam int          IFU_MEM_TIMEOUT = 15;

    // Next-PC calculator operations (produced upstream, listed here so the
    // fetch and next-PC blocks share one header)
    typedef enum logic [1:0] {
        NPC_OP_SEQ    = 2'd0,
        NPC_OP_BRANCH = 2'd1,
        NPC_OP_JUMP   = 2'd2,
        NPC_OP_JREG   = 2'd3
    } npc_op_e;

    // Fetch-unit control states
    typedef enum logic [2:0] {
        IFU_STATE_IDLE  = 3'd0,
        IFU_STATE_REQ   = 3'd1,
        IFU_STATE_VALID = 3'd2,
        IFU_STATE_HALT  = 3'd3,
        IFU_STATE_FAULT = 3'd4
    } ifu_state_e;

    // Drop the byte offset so the PC always names a whole word
    function automatic logic [31:0] ifu_word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic ifu_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: next-PC/ready from the core, req/ack instruction memory
// port, and the fetched word plus status back to the core.
// master = fetch unit, slave = core + memory side.
interface instruction_fetch_unit_if;
    // core -> fetch
    logic [31:0] npc;
    logic        instr_ready;
    // memory -> fetch
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // fetch -> memory
    logic        imem_req;
    logic [31:0] imem_addr;
    // fetch -> core
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    modport master (
        input  npc, instr_ready, imem_ack, imem_rdata,
        output imem_req, imem_addr, pc, instr, instr_valid, halted, fault
    );

    modport slave (
        output npc, instr_ready, imem_ack, imem_rdata,
        input  imem_req, imem_addr, pc, instr, instr_valid, halted, fault
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_timeout_counter.sv
// Saturating wait counter for an outstanding fetch; o_expired flags the cycle
// whose increment reaches MEM_TIMEOUT (combinational, same cycle as enable).
// Ports: clk, rst (sync, active-high), i_clear, i_enable, o_expired.
module fetch_timeout_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = IFU_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int            CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    // Saturate at LIMIT so the count never wraps back to a "fresh" value
    assign w_count_next = (r_count == LIMIT) ? LIMIT : r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_count_next;
        end
    end

    // Fires in the MEM_TIMEOUT-th waiting cycle so the fault lands next cycle
    assign o_expired = i_enable && (w_count_next == LIMIT);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch stage: holds PC, issues req/ack fetches, presents the word
// to decode, detects halt (npc == pc) and fetch timeouts. Zero-wait memory
// gives 2 cycles/instruction; instr is held stable while instr_ready is low.
// Ports: clk, rst (sync, active-high), bus (instruction_fetch_unit_if.master).
// Build option: IFU_ALIGN_CHECK_EN faults on a misaligned npc instead of
// silently clearing npc[1:0].
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
    parameter int          MEM_TIMEOUT = IFU_MEM_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    instruction_fetch_unit_if.master       bus
);
    ifu_state_e  r_state;
    ifu_state_e  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic        w_accept;
    logic        w_expired;
    logic        w_cnt_clear;
    logic        w_cnt_en;

    assign w_accept = (r_state == IFU_STATE_VALID) && bus.instr_ready;

    // Counter runs only while a request is outstanding; any other state
    // leaves it at zero, so every entry into REQ starts a fresh budget.
    assign w_cnt_clear = (r_state != IFU_STATE_REQ);
    assign w_cnt_en    = (r_state == IFU_STATE_REQ) && !bus.imem_ack;

    fetch_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        case (r_state)
            IFU_STATE_IDLE: begin
                w_state_next = IFU_STATE_REQ;
            end
            IFU_STATE_REQ: begin
                // ack takes priority over an expiry in the same cycle
                if (bus.imem_ack) begin
                    w_instr_next = bus.imem_rdata;
                    w_state_next = IFU_STATE_VALID;
                end else if (w_expired) begin
                    w_state_next = IFU_STATE_FAULT;
                end
            end
            IFU_STATE_VALID: begin
                if (w_accept) begin
                    if (bus.npc == r_pc) begin
                        w_state_next = IFU_STATE_HALT;
`ifdef IFU_ALIGN_CHECK_EN
                    end else if (ifu_misaligned(bus.npc)) begin
                        w_state_next = IFU_STATE_FAULT;
`endif
                    end else begin
                        w_pc_next    = ifu_word_align(bus.npc);
                        w_state_next = IFU_STATE_REQ;
                    end
                end
            end
            IFU_STATE_HALT,
            IFU_STATE_FAULT: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = IFU_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IFU_STATE_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
        end
    end

    assign bus.imem_req    = (r_state == IFU_STATE_REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == IFU_STATE_VALID);
    assign bus.halted      = (r_state == IFU_STATE_HALT);
    assign bus.fault       = (r_state == IFU_STATE_FAULT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a cycle-level reference model
// and per-cycle comparison, plus literal expectations at key points.
// Honours IFU_ALIGN_CHECK_EN in the same way as the design.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TO     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Flags describe what the fetch stage is doing, not how it is encoded.
    logic [31:0] m_pc, m_instr;
    logic        m_req, m_valid, m_halt, m_fault, m_live;
    int          m_wait;

    initial begin
        m_live = 1'b0; m_pc = '0; m_instr = '0; m_req = 0; m_valid = 0;
        m_halt = 0; m_fault = 0; m_wait = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_pc = RST_PC; m_instr = '0; m_req = 0;
            m_valid = 0; m_halt = 0; m_fault = 0; m_wait = 0;
        end else if (m_live && !m_halt && !m_fault) begin
            if (m_req) begin
                if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata; m_req = 0; m_valid = 1;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait >= TO) begin m_req = 0; m_fault = 1; end
                end
            end else if (m_valid) begin
                if (bus.instr_ready) begin
                    m_valid = 0;
                    if (bus.npc == m_pc) m_halt = 1;
`ifdef IFU_ALIGN_CHECK_EN
                    else if (bus.npc[1:0] != 2'b00) m_fault = 1;
`endif
                    else begin
                        m_pc = bus.npc & 32'hFFFF_FFFC; m_req = 1; m_wait = 0;
                    end
                end
            end else begin
                // just left reset: first request goes out next cycle
                m_req = 1; m_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_req",    bus.imem_req,    m_req);
            chk("m_addr",   bus.imem_addr,   m_pc);
            chk("m_pc",     bus.pc,          m_pc);
            chk("m_instr",  bus.instr,       m_instr);
            chk("m_valid",  bus.instr_valid, m_valid);
            chk("m_halted", bus.halted,      m_halt);
            chk("m_fault",  bus.fault,       m_fault);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.npc = '0; bus.instr_ready = 0; bus.imem_ack = 0; bus.imem_rdata = '0;
        rst = 1;
        tick(); tick();
        chk("rst_req",    bus.imem_req,    0);
        chk("rst_pc",     bus.pc,          32'h0000_3000);
        chk("rst_instr",  bus.instr,       0);
        chk("rst_valid",  bus.instr_valid, 0);
        chk("rst_halted", bus.halted,      0);
        chk("rst_fault",  bus.fault,       0);

        // zero-wait memory
        rst = 0;
        tick();
        chk("zw_req1",  bus.imem_req,  1);
        chk("zw_addr1", bus.imem_addr, 32'h0000_3000);
        bus.imem_ack = 1; bus.imem_rdata = 32'h2001_0005;
        tick();
        chk("zw_valid2", bus.instr_valid, 1);
        chk("zw_instr2", bus.instr,       32'h2001_0005);
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'h0000_3004;
        tick();
        bus.instr_ready = 0;
        chk("zw_req3",  bus.imem_req,  1);
        chk("zw_addr3", bus.imem_addr, 32'h0000_3004);

        // 3-cycle ack latency, then core stalls 4 cycles
        tick();
        chk("lat_addr", bus.imem_addr, 32'h0000_3004);
        tick();
        chk("lat_addr", bus.imem_addr, 32'h0000_3004);
        bus.imem_ack = 1; bus.imem_rdata = 32'hA5A5_0001;
        tick();
        bus.imem_rdata = 32'hDEAD_BEEF;  // ack outside REQ must be ignored
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", bus.instr_valid, 1);
            chk("stall_instr", bus.instr,       32'hA5A5_0001);
            chk("stall_pc",    bus.pc,          32'h0000_3004);
            tick();
        end
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'h0000_3008;
        tick();
        bus.instr_ready = 0;
        chk("stall_next", bus.imem_addr, 32'h0000_3008);

        // halt on npc == pc
        bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678;
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'h0000_3008;
        tick();
        bus.instr_ready = 0;
        chk("halt_flag", bus.halted, 1);
        chk("halt_pc",   bus.pc,     32'h0000_3008);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = i[0];
            tick();
            chk("halt_noreq", bus.imem_req, 0);
        end
        bus.imem_ack = 0;

        // timeout with no ack, then restart
        rst = 1; tick(); rst = 0;
        tick();
        chk("to_req", bus.imem_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_nofault", bus.fault, 0);
        end
        tick();
        chk("to_fault", bus.fault,    1);
        chk("to_noreq", bus.imem_req, 0);
        rst = 1; tick();
        chk("to_rst_fault", bus.fault, 0);
        chk("to_rst_pc",    bus.pc,    32'h0000_3000);
        rst = 0; tick();
        chk("to_restart", bus.imem_addr, 32'h0000_3000);

        // misaligned npc
        bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0013;
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'h0000_3006;
        tick();
        bus.instr_ready = 0;
`ifdef IFU_ALIGN_CHECK_EN
        chk("align_fault", bus.fault,    1);
        chk("align_pc",    bus.pc,       32'h0000_3000);
        chk("align_noreq", bus.imem_req, 0);
`else
        chk("align_pc",  bus.pc,       32'h0000_3004);
        chk("align_req", bus.imem_req, 1);
`endif

        // reset while requesting, late ack ignored
        rst = 1; tick(); rst = 0; tick();
        chk("mid_req", bus.imem_req, 1);
        rst = 1; tick();
        chk("mid_rst_req", bus.imem_req, 0);
        rst = 0; bus.imem_ack = 1; bus.imem_rdata = 32'hBAD0_0BAD;
        tick();
        bus.imem_ack = 0;
        chk("mid_valid", bus.instr_valid, 0);
        chk("mid_instr", bus.instr,       0);
        chk("mid_addr",  bus.imem_addr,   32'h0000_3000);

        // pc wrap, then ack in the last allowed wait cycle
        bus.imem_ack = 1; bus.imem_rdata = 32'h1111_1111;
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'hFFFF_FFFC;
        tick();
        bus.instr_ready = 0;
        chk("wrap_hi", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_ack = 1; bus.imem_rdata = 32'h2222_2222;
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1; bus.npc = 32'h0000_0000;
        tick();
        bus.instr_ready = 0;
        chk("wrap_zero", bus.imem_addr, 32'h0000_0000);
        tick(); tick(); tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'h3333_3333;
        tick();
        bus.imem_ack = 0;
        chk("race_valid", bus.instr_valid, 1);
        chk("race_fault", bus.fault,       0);
        chk("race_instr", bus.instr,       32'h3333_3333);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
